// File: rtl/cpu_pkg.sv
// Shared CPU datapath constants and ALU op encodings.
// Used by the operand stage and its forwarding resolver.
package cpu_pkg;

  localparam int WIDTH = 16;
  localparam int RADDR = 4;

  typedef enum logic {
    ALU_ADD = 1'b0,
    ALU_SUB = 1'b1
  } alu_op_e;

  localparam logic [RADDR-1:0] R0 = '0;

endpackage

// File: rtl/fwd_mux.sv
// Per-operand RAW resolver: R0 reads as zero, then the EX/MEM result, then the WB result,
// otherwise the register file read data.
module fwd_mux
  import cpu_pkg::*;
#(
  parameter int W = cpu_pkg::WIDTH,
  parameter int A = cpu_pkg::RADDR
) (
  input  logic [A-1:0] addr_i,
  input  logic [W-1:0] rf_data_i,
  input  logic         exm_we_i,
  input  logic [A-1:0] exm_rd_i,
  input  logic [W-1:0] exm_result_i,
  input  logic         wb_we_i,
  input  logic [A-1:0] wb_rd_i,
  input  logic [W-1:0] wb_result_i,
  output logic [W-1:0] data_o
);

  // NOTE: give every always_comb output a value on every path (here via the
  // if/else chain ending in a plain else) or synthesis infers a latch.
  always_comb begin
    if (addr_i == R0) begin
      data_o = '0;
    end else if (exm_we_i && (exm_rd_i == addr_i)) begin
      // EX/MEM holds the newer value when both stages target the same register.
      data_o = exm_result_i;
    end else if (wb_we_i && (wb_rd_i == addr_i)) begin
      data_o = wb_result_i;
    end else begin
      data_o = rf_data_i;
    end
  end

endmodule

// File: rtl/alu_operand_stage.sv
// ID/EX register feeding the ALU: valid/ready capture with EX/MEM and WB forwarding,
// immediate select, and WB refresh of stored operands while the stage is held.
module alu_operand_stage
  import cpu_pkg::*;
#(
  parameter int WIDTH = cpu_pkg::WIDTH,
  parameter int RADDR = cpu_pkg::RADDR
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [RADDR-1:0] RS1_ADDR,
  input  logic [RADDR-1:0] RS2_ADDR,
  input  logic [WIDTH-1:0] RS1_DATA,
  input  logic [WIDTH-1:0] RS2_DATA,
  input  logic [WIDTH-1:0] IMM,
  input  logic             USE_IMM,
  input  logic             OP_IN,
  input  logic [RADDR-1:0] RD_ADDR_IN,
  input  logic             REG_WRITE_IN,
  input  logic             FLUSH,
  input  logic             EXM_REG_WRITE,
  input  logic [RADDR-1:0] EXM_RD_ADDR,
  input  logic [WIDTH-1:0] EXM_RESULT,
  input  logic             WB_REG_WRITE,
  input  logic [RADDR-1:0] WB_RD_ADDR,
  input  logic [WIDTH-1:0] WB_RESULT,
  input  logic             OUT_READY,
  output logic             OUT_VALID,
  output logic [WIDTH-1:0] SRCA,
  output logic [WIDTH-1:0] SRCB,
  output logic             OP,
  output logic [RADDR-1:0] RD_ADDR_OUT,
  output logic             REG_WRITE_OUT
);

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] srca_q, srca_d;
  logic [WIDTH-1:0] srcb_q, srcb_d;
  alu_op_e          op_q, op_d;
  logic [RADDR-1:0] rd_q, rd_d;
  logic             reg_write_q, reg_write_d;
  logic [RADDR-1:0] rs1_q, rs1_d;
  logic [RADDR-1:0] rs2_q, rs2_d;
  logic             use_imm_q, use_imm_d;

  logic [WIDTH-1:0] fwd_a, fwd_b;
  logic             xfer_in;

  fwd_mux #(.W(WIDTH), .A(RADDR)) u_fwd_a (
    .addr_i      (RS1_ADDR),
    .rf_data_i   (RS1_DATA),
    .exm_we_i    (EXM_REG_WRITE),
    .exm_rd_i    (EXM_RD_ADDR),
    .exm_result_i(EXM_RESULT),
    .wb_we_i     (WB_REG_WRITE),
    .wb_rd_i     (WB_RD_ADDR),
    .wb_result_i (WB_RESULT),
    .data_o      (fwd_a)
  );

  fwd_mux #(.W(WIDTH), .A(RADDR)) u_fwd_b (
    .addr_i      (RS2_ADDR),
    .rf_data_i   (RS2_DATA),
    .exm_we_i    (EXM_REG_WRITE),
    .exm_rd_i    (EXM_RD_ADDR),
    .exm_result_i(EXM_RESULT),
    .wb_we_i     (WB_REG_WRITE),
    .wb_rd_i     (WB_RD_ADDR),
    .wb_result_i (WB_RESULT),
    .data_o      (fwd_b)
  );

  assign IN_READY = !out_valid_q || OUT_READY;
  assign xfer_in  = IN_VALID && IN_READY;

  always_comb begin
    out_valid_d = out_valid_q;
    srca_d      = srca_q;
    srcb_d      = srcb_q;
    op_d        = op_q;
    rd_d        = rd_q;
    reg_write_d = reg_write_q;
    rs1_d       = rs1_q;
    rs2_d       = rs2_q;
    use_imm_d   = use_imm_q;

    if (FLUSH) begin
      out_valid_d = 1'b0;
    end else if (xfer_in) begin
      out_valid_d = 1'b1;
      srca_d      = fwd_a;
      srcb_d      = USE_IMM ? IMM : fwd_b;
      op_d        = alu_op_e'(OP_IN);
      rd_d        = RD_ADDR_IN;
      reg_write_d = REG_WRITE_IN;
      rs1_d       = RS1_ADDR;
      rs2_d       = RS2_ADDR;
      use_imm_d   = USE_IMM;
    end else if (out_valid_q && OUT_READY) begin
      out_valid_d = 1'b0;
    end else if (out_valid_q) begin
      // Held: only a WB write may update a stored register operand; EX/MEM is ignored.
      if (WB_REG_WRITE && (rs1_q != R0) && (WB_RD_ADDR == rs1_q)) begin
        srca_d = WB_RESULT;
      end
      if (WB_REG_WRITE && !use_imm_q && (rs2_q != R0) && (WB_RD_ADDR == rs2_q)) begin
        srcb_d = WB_RESULT;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      out_valid_q <= 1'b0;
      srca_q      <= '0;
      srcb_q      <= '0;
      op_q        <= ALU_ADD;
      rd_q        <= '0;
      reg_write_q <= 1'b0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      use_imm_q   <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      srca_q      <= srca_d;
      srcb_q      <= srcb_d;
      op_q        <= op_d;
      rd_q        <= rd_d;
      reg_write_q <= reg_write_d;
      rs1_q       <= rs1_d;
      rs2_q       <= rs2_d;
      use_imm_q   <= use_imm_d;
    end
  end

  assign OUT_VALID     = out_valid_q;
  assign SRCA          = srca_q;
  assign SRCB          = srcb_q;
  assign OP            = op_q;
  assign RD_ADDR_OUT   = rd_q;
  assign REG_WRITE_OUT = reg_write_q && out_valid_q;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Bench for alu_operand_stage: directed vector table, hand-written hold/reset/flush
// sequences, then randomized traffic against a behavioural model.
module tb_alu_operand_stage;

  localparam int W = 16;
  localparam int A = 4;

  logic         CLK = 1'b0;
  logic         RESET;
  logic         IN_VALID, IN_READY;
  logic [A-1:0] RS1_ADDR, RS2_ADDR, RD_ADDR_IN;
  logic [W-1:0] RS1_DATA, RS2_DATA, IMM;
  logic         USE_IMM, OP_IN, REG_WRITE_IN, FLUSH;
  logic         EXM_REG_WRITE, WB_REG_WRITE;
  logic [A-1:0] EXM_RD_ADDR, WB_RD_ADDR;
  logic [W-1:0] EXM_RESULT, WB_RESULT;
  logic         OUT_READY, OUT_VALID;
  logic [W-1:0] SRCA, SRCB;
  logic         OP;
  logic [A-1:0] RD_ADDR_OUT;
  logic         REG_WRITE_OUT;

  int n_cmp  = 0;
  int n_fail = 0;

  alu_operand_stage dut (
    .CLK(CLK), .RESET(RESET),
    .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .RS1_ADDR(RS1_ADDR), .RS2_ADDR(RS2_ADDR),
    .RS1_DATA(RS1_DATA), .RS2_DATA(RS2_DATA),
    .IMM(IMM), .USE_IMM(USE_IMM), .OP_IN(OP_IN),
    .RD_ADDR_IN(RD_ADDR_IN), .REG_WRITE_IN(REG_WRITE_IN),
    .FLUSH(FLUSH),
    .EXM_REG_WRITE(EXM_REG_WRITE), .EXM_RD_ADDR(EXM_RD_ADDR), .EXM_RESULT(EXM_RESULT),
    .WB_REG_WRITE(WB_REG_WRITE), .WB_RD_ADDR(WB_RD_ADDR), .WB_RESULT(WB_RESULT),
    .OUT_READY(OUT_READY), .OUT_VALID(OUT_VALID),
    .SRCA(SRCA), .SRCB(SRCB), .OP(OP),
    .RD_ADDR_OUT(RD_ADDR_OUT), .REG_WRITE_OUT(REG_WRITE_OUT)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [A-1:0] rs1_a, rs2_a;
    logic [W-1:0] rs1_d, rs2_d, imm;
    logic         use_imm, op;
    logic [A-1:0] rd;
    logic         rw;
    logic         exm_we;
    logic [A-1:0] exm_rd;
    logic [W-1:0] exm_res;
    logic         wb_we;
    logic [A-1:0] wb_rd;
    logic [W-1:0] wb_res;
    logic [W-1:0] exp_a, exp_b;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mkv(
    input logic [A-1:0] rs1_a, input logic [W-1:0] rs1_d,
    input logic [A-1:0] rs2_a, input logic [W-1:0] rs2_d,
    input logic use_imm, input logic [W-1:0] imm, input logic op,
    input logic [A-1:0] rd, input logic rw,
    input logic exm_we, input logic [A-1:0] exm_rd, input logic [W-1:0] exm_res,
    input logic wb_we, input logic [A-1:0] wb_rd, input logic [W-1:0] wb_res,
    input logic [W-1:0] exp_a, input logic [W-1:0] exp_b);
    vec_t v;
    v.rs1_a = rs1_a; v.rs1_d = rs1_d; v.rs2_a = rs2_a; v.rs2_d = rs2_d;
    v.use_imm = use_imm; v.imm = imm; v.op = op; v.rd = rd; v.rw = rw;
    v.exm_we = exm_we; v.exm_rd = exm_rd; v.exm_res = exm_res;
    v.wb_we = wb_we; v.wb_rd = wb_rd; v.wb_res = wb_res;
    v.exp_a = exp_a; v.exp_b = exp_b;
    return v;
  endfunction

  task automatic idle_inputs();
    IN_VALID = 0; RS1_ADDR = 0; RS2_ADDR = 0; RS1_DATA = 0; RS2_DATA = 0;
    IMM = 0; USE_IMM = 0; OP_IN = 0; RD_ADDR_IN = 0; REG_WRITE_IN = 0; FLUSH = 0;
    EXM_REG_WRITE = 0; EXM_RD_ADDR = 0; EXM_RESULT = 0;
    WB_REG_WRITE = 0; WB_RD_ADDR = 0; WB_RESULT = 0;
  endtask

  task automatic drive_vec(input vec_t v);
    IN_VALID = 1;
    RS1_ADDR = v.rs1_a; RS1_DATA = v.rs1_d; RS2_ADDR = v.rs2_a; RS2_DATA = v.rs2_d;
    USE_IMM = v.use_imm; IMM = v.imm; OP_IN = v.op; RD_ADDR_IN = v.rd; REG_WRITE_IN = v.rw;
    EXM_REG_WRITE = v.exm_we; EXM_RD_ADDR = v.exm_rd; EXM_RESULT = v.exm_res;
    WB_REG_WRITE = v.wb_we; WB_RD_ADDR = v.wb_rd; WB_RESULT = v.wb_res;
  endtask

  task automatic drive_simple(input logic [A-1:0] rs1_a, input logic [W-1:0] rs1_d,
                              input logic [A-1:0] rs2_a, input logic [W-1:0] rs2_d);
    idle_inputs();
    IN_VALID = 1;
    RS1_ADDR = rs1_a; RS1_DATA = rs1_d; RS2_ADDR = rs2_a; RS2_DATA = rs2_d;
  endtask

  // Reference: value an architectural read of `addr` sees, newest producer first.
  function automatic logic [W-1:0] ref_read(
    input logic [A-1:0] addr, input logic [W-1:0] rf,
    input logic exm_we, input logic [A-1:0] exm_rd, input logic [W-1:0] exm_res,
    input logic wb_we, input logic [A-1:0] wb_rd, input logic [W-1:0] wb_res);
    if (addr == 0) return '0;
    if (exm_we && exm_rd == addr) return exm_res;
    if (wb_we && wb_rd == addr) return wb_res;
    return rf;
  endfunction

  // Model of the one instruction the stage can hold.
  logic         m_valid;
  logic [W-1:0] m_a, m_b;
  logic         m_op, m_rw, m_imm;
  logic [A-1:0] m_rd, m_rs1, m_rs2;

  initial begin
    vecs[0] = mkv(4'd1, 16'd5,    4'd2, 16'hFFFD, 0, 16'h0000, 0, 4'd7, 1,
                  0, 4'd0, 16'h0,   0, 4'd0, 16'h0,    16'd5,    16'hFFFD);
    vecs[1] = mkv(4'd3, 16'd1,    4'd4, 16'h1234, 0, 16'h0000, 1, 4'd8, 0,
                  1, 4'd3, 16'd7,   1, 4'd3, 16'd9,    16'd7,    16'h1234);
    vecs[2] = mkv(4'd3, 16'd1,    4'd4, 16'h1234, 0, 16'h0000, 0, 4'd9, 1,
                  0, 4'd3, 16'd7,   1, 4'd3, 16'd9,    16'd9,    16'h1234);
    vecs[3] = mkv(4'd0, 16'd1,    4'd0, 16'h0055, 0, 16'h0000, 1, 4'd1, 1,
                  1, 4'd0, 16'd7,   1, 4'd0, 16'd9,    16'd0,    16'd0);
    vecs[4] = mkv(4'd2, 16'hAAAA, 4'd5, 16'h0010, 1, 16'hFFFC, 0, 4'd2, 1,
                  1, 4'd5, 16'h77,  0, 4'd0, 16'h0,    16'hAAAA, 16'hFFFC);
    vecs[5] = mkv(4'd6, 16'd1,    4'd7, 16'd2,    0, 16'h0000, 1, 4'd3, 0,
                  1, 4'd6, 16'h66,  1, 4'd7, 16'h7777, 16'h0066, 16'h7777);
    vecs[6] = mkv(4'd6, 16'h1111, 4'd6, 16'h2222, 0, 16'h0000, 0, 4'd4, 1,
                  0, 4'd6, 16'd5,   0, 4'd6, 16'd5,    16'h1111, 16'h2222);
    vecs[7] = mkv(4'd1, 16'd0,    4'd2, 16'd0,    0, 16'h0000, 1, 4'd5, 1,
                  1, 4'd1, 16'hE1,  1, 4'd2, 16'hB2,   16'h00E1, 16'h00B2);

    idle_inputs();
    OUT_READY = 0;
    RESET = 1;
    #3;
    check("reset_out_valid", 32'(OUT_VALID), 0);
    check("reset_srca", 32'(SRCA), 0);
    check("reset_srcb", 32'(SRCB), 0);
    check("reset_op", 32'(OP), 0);
    check("reset_rd", 32'(RD_ADDR_OUT), 0);
    check("reset_reg_write", 32'(REG_WRITE_OUT), 0);
    @(negedge CLK);
    RESET = 0;

    // Table: one instruction per cycle, OUT_READY high.
    OUT_READY = 1;
    for (int i = 0; i < 8; i++) begin
      drive_vec(vecs[i]);
      @(negedge CLK);
      check($sformatf("vec%0d_valid", i), 32'(OUT_VALID), 1);
      check($sformatf("vec%0d_srca", i), 32'(SRCA), 32'(vecs[i].exp_a));
      check($sformatf("vec%0d_srcb", i), 32'(SRCB), 32'(vecs[i].exp_b));
      check($sformatf("vec%0d_op", i), 32'(OP), 32'(vecs[i].op));
      check($sformatf("vec%0d_rd", i), 32'(RD_ADDR_OUT), 32'(vecs[i].rd));
      check($sformatf("vec%0d_regw", i), 32'(REG_WRITE_OUT), 32'(vecs[i].rw));
    end
    idle_inputs();
    @(negedge CLK);
    check("drain_valid", 32'(OUT_VALID), 0);
    check("drain_regw", 32'(REG_WRITE_OUT), 0);

    // Stall refresh from WB, immune to EX/MEM.
    drive_simple(4'd1, 16'h0011, 4'd5, 16'h0022);
    @(negedge CLK);
    check("hold_cap_valid", 32'(OUT_VALID), 1);
    check("hold_cap_srcb", 32'(SRCB), 32'h22);
    idle_inputs();
    OUT_READY = 0;
    WB_REG_WRITE = 1; WB_RD_ADDR = 4'd5; WB_RESULT = 16'h0042;
    #1 check("hold_in_ready0", 32'(IN_READY), 0);
    @(negedge CLK);
    check("hold_refresh_srcb", 32'(SRCB), 32'h42);
    check("hold_refresh_srca", 32'(SRCA), 32'h11);
    check("hold_valid1", 32'(OUT_VALID), 1);
    drive_simple(4'd2, 16'h0BAD, 4'd3, 16'h0BAD);
    WB_REG_WRITE = 1; WB_RD_ADDR = 4'd6; WB_RESULT = 16'h0099;
    EXM_REG_WRITE = 1; EXM_RD_ADDR = 4'd1; EXM_RESULT = 16'h00EE;
    #1 check("hold_in_ready1", 32'(IN_READY), 0);
    @(negedge CLK);
    check("hold_other_srca", 32'(SRCA), 32'h11);
    check("hold_other_srcb", 32'(SRCB), 32'h42);
    check("hold_valid2", 32'(OUT_VALID), 1);

    // Reset mid-hold clears outputs before the next edge.
    idle_inputs();
    #2 RESET = 1;
    #1;
    check("midrst_valid", 32'(OUT_VALID), 0);
    check("midrst_srca", 32'(SRCA), 0);
    check("midrst_srcb", 32'(SRCB), 0);
    check("midrst_regw", 32'(REG_WRITE_OUT), 0);
    @(negedge CLK);
    RESET = 0;

    // Flush, then four back-to-back instructions.
    OUT_READY = 1;
    drive_simple(4'd1, 16'h000A, 4'd0, 16'h0);
    @(negedge CLK);
    check("flush_pre_valid", 32'(OUT_VALID), 1);
    check("flush_pre_srca", 32'(SRCA), 32'hA);
    drive_simple(4'd1, 16'h000B, 4'd0, 16'h0);
    FLUSH = 1;
    #1 check("flush_in_ready", 32'(IN_READY), 1);
    @(negedge CLK);
    check("flush_valid", 32'(OUT_VALID), 0);
    for (int k = 0; k < 4; k++) begin
      drive_simple(4'd1, 16'(16'h0100 + k), 4'd0, 16'h0);
      @(negedge CLK);
      check($sformatf("b2b%0d_valid", k), 32'(OUT_VALID), 1);
      check($sformatf("b2b%0d_srca", k), 32'(SRCA), 32'h100 + 32'(k));
    end
    idle_inputs();
    @(negedge CLK);
    check("b2b_end_valid", 32'(OUT_VALID), 0);

    // Randomized traffic against the model.
    RESET = 1;
    @(negedge CLK);
    RESET = 0;
    m_valid = 0; m_a = 0; m_b = 0; m_op = 0; m_rw = 0; m_imm = 0;
    m_rd = 0; m_rs1 = 0; m_rs2 = 0;
    for (int c = 0; c < 600; c++) begin
      logic in_rdy;
      check("rnd_valid", 32'(OUT_VALID), 32'(m_valid));
      check("rnd_regw", 32'(REG_WRITE_OUT), 32'(m_rw && m_valid));
      if (m_valid) begin
        check("rnd_srca", 32'(SRCA), 32'(m_a));
        check("rnd_srcb", 32'(SRCB), 32'(m_b));
        check("rnd_op", 32'(OP), 32'(m_op));
        check("rnd_rd", 32'(RD_ADDR_OUT), 32'(m_rd));
      end
      IN_VALID      = ($urandom_range(0, 9) < 7);
      OUT_READY     = ($urandom_range(0, 9) < 6);
      FLUSH         = ($urandom_range(0, 11) == 0);
      RS1_ADDR      = A'($urandom_range(0, 3));
      RS2_ADDR      = A'($urandom_range(0, 3));
      RS1_DATA      = W'($urandom);
      RS2_DATA      = W'($urandom);
      IMM           = W'($urandom);
      USE_IMM       = ($urandom_range(0, 9) < 3);
      OP_IN         = 1'($urandom);
      RD_ADDR_IN    = A'($urandom);
      REG_WRITE_IN  = 1'($urandom);
      EXM_REG_WRITE = 1'($urandom);
      EXM_RD_ADDR   = A'($urandom_range(0, 3));
      EXM_RESULT    = W'($urandom);
      WB_REG_WRITE  = 1'($urandom);
      WB_RD_ADDR    = A'($urandom_range(0, 3));
      WB_RESULT     = W'($urandom);
      in_rdy = !m_valid || OUT_READY;
      #1 check("rnd_in_ready", 32'(IN_READY), 32'(in_rdy));
      if (FLUSH) begin
        m_valid = 0;
      end else if (IN_VALID && in_rdy) begin
        m_valid = 1;
        m_a = ref_read(RS1_ADDR, RS1_DATA, EXM_REG_WRITE, EXM_RD_ADDR, EXM_RESULT,
                       WB_REG_WRITE, WB_RD_ADDR, WB_RESULT);
        m_b = USE_IMM ? IMM
                      : ref_read(RS2_ADDR, RS2_DATA, EXM_REG_WRITE, EXM_RD_ADDR, EXM_RESULT,
                                 WB_REG_WRITE, WB_RD_ADDR, WB_RESULT);
        m_op = OP_IN; m_rd = RD_ADDR_IN; m_rw = REG_WRITE_IN;
        m_rs1 = RS1_ADDR; m_rs2 = RS2_ADDR; m_imm = USE_IMM;
      end else if (m_valid && OUT_READY) begin
        m_valid = 0;
      end else if (m_valid) begin
        if (WB_REG_WRITE && m_rs1 != 0 && WB_RD_ADDR == m_rs1) m_a = WB_RESULT;
        if (WB_REG_WRITE && !m_imm && m_rs2 != 0 && WB_RD_ADDR == m_rs2) m_b = WB_RESULT;
      end
      @(negedge CLK);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
